// File: rtl/fbwg_pkg.sv
// Shared definitions for the player-character blocks: screen and tile-map
// geometry, tile codes, the collision probe FSM states and the tile-map
// address helper.
package fbwg_pkg;

  // Tile map geometry: 16x16 pixel tiles, 40 columns across the screen
  localparam int TILE_SHIFT = 4;
  localparam int MAP_COLS   = 40;

  // Visible screen size in pixels
  localparam int SCREEN_W = MAP_COLS << TILE_SHIFT;
  localparam int SCREEN_H = 480;

  // Tile codes stored in the level ROM
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WALL  = 2'd1,
    WATER = 2'd2,
    LAVA  = 2'd3
  } tile_t;

  // Collision probe sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } probe_state_t;

  // row*40 + col built from shifts: 32 + 8 columns per row
  function automatic logic [10:0] map_addr(input logic [10:0] row,
                                           input logic [10:0] col);
    return (row << 5) + (row << 3) + col;
  endfunction

endpackage

// File: rtl/collision_probe_if.sv
// Bus between the collision probe, its tile-map ROM and the motion stage.
// The master side is the surrounding system (frame timing, position source,
// ROM data); the slave side is the probe itself.
interface collision_probe_if;

  logic        frame_start;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [10:0] tile_addr;
  logic [1:0]  tile_data;
  logic        fLeft;
  logic        fRight;
  logic        fTop;
  logic        fBottom;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output frame_start, pos_x, pos_y, tile_data,
    input  tile_addr, fLeft, fRight, fTop, fBottom, busy, done, overrun
  );

  modport slave (
    input  frame_start, pos_x, pos_y, tile_data,
    output tile_addr, fLeft, fRight, fTop, fBottom, busy, done, overrun
  );

endinterface

// File: rtl/probe_point_gen.sv
// Combinational probe point generator: for probe index k around the latched
// character centre, produces the tile-map ROM address and whether the probe
// lies outside the visible screen (in which case the address is 0).
module probe_point_gen
  import fbwg_pkg::*;
#(
  parameter int HALF    = 13,
  parameter int STEP_X  = 3,
  parameter int STEP_UP = 5,
  parameter int STEP_DN = 2
) (
  input  logic [2:0]  k,
  input  logic [9:0]  x_c,
  input  logic [9:0]  y_c,
  output logic [10:0] tile_addr,
  output logic        off_screen
);

  localparam logic signed [10:0] H     = 11'(HALF);
  localparam logic signed [10:0] SX    = 11'(STEP_X);
  localparam logic signed [10:0] SU    = 11'(STEP_UP);
  localparam logic signed [10:0] SD    = 11'(STEP_DN);
  localparam logic signed [10:0] ONE   = 11'sd1;
  localparam logic signed [10:0] ZERO  = 11'sd0;
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

  logic signed [10:0] xs;
  logic signed [10:0] ys;
  logic signed [10:0] px;
  logic signed [10:0] py;
  logic [10:0]        px_u;
  logic [10:0]        py_u;
  logic [10:0]        row;
  logic [10:0]        col;

  assign xs = signed'({1'b0, x_c});
  assign ys = signed'({1'b0, y_c});

  // Probe coordinates: pairs left, right, top, bottom, each pair inset one
  // pixel from the character corners along the edge being tested
  always_comb begin
    px = xs;
    py = ys;
    case (k)
      3'd0: begin px = xs - H - SX;  py = ys - H + ONE; end
      3'd1: begin px = xs - H - SX;  py = ys + H - ONE; end
      3'd2: begin px = xs + H + SX;  py = ys - H + ONE; end
      3'd3: begin px = xs + H + SX;  py = ys + H - ONE; end
      3'd4: begin px = xs - H + ONE; py = ys - H - SU;  end
      3'd5: begin px = xs + H - ONE; py = ys - H - SU;  end
      3'd6: begin px = xs - H + ONE; py = ys + H + SD;  end
      3'd7: begin px = xs + H - ONE; py = ys + H + SD;  end
      default: begin px = xs; py = ys; end
    endcase
  end

  // Off-screen check on the signed coordinates, then row/col address for
  // on-screen probes only
  always_comb begin
    off_screen = (px < ZERO) || (px > X_MAX) || (py < ZERO) || (py > Y_MAX);
    px_u       = px;
    py_u       = py;
    row        = py_u >> TILE_SHIFT;
    col        = px_u >> TILE_SHIFT;
    tile_addr  = off_screen ? 11'd0 : map_addr(row, col);
  end

endmodule

// File: rtl/collision_probe.sv
// Per-frame terrain sensor for one player character. On frame_start it
// samples eight tile-map probe points around the character and publishes
// four "direction free" flags together, for the motion stage's next tick.
module collision_probe
  import fbwg_pkg::*;
#(
  parameter int         HALF    = 13,
  parameter int         STEP_X  = 3,
  parameter int         STEP_UP = 5,
  parameter int         STEP_DN = 2,
  parameter logic [1:0] SOLID   = 2'b01
) (
  input logic               Clk,
  input logic               Reset_n,
  collision_probe_if.slave  bus
);

  probe_state_t state;
  logic [2:0]   k;
  logic [1:0]   prev_dir;
  logic         prev_off;
  logic [9:0]   x_lat;
  logic [9:0]   y_lat;
  logic [3:0]   blk;
  logic [3:0]   blk_next;
  logic [3:0]   flags;
  logic         busy_q;
  logic         done_q;
  logic [10:0]  gen_addr;
  logic         gen_off;
  logic         probe_solid;

  probe_point_gen #(
    .HALF    (HALF),
    .STEP_X  (STEP_X),
    .STEP_UP (STEP_UP),
    .STEP_DN (STEP_DN)
  ) u_gen (
    .k          (k),
    .x_c        (x_lat),
    .y_c        (y_lat),
    .tile_addr  (gen_addr),
    .off_screen (gen_off)
  );

  // Fold the probe whose ROM data is arriving now into its direction's
  // blocked bit; an off-screen probe counts as solid regardless of the ROM
  always_comb begin
    probe_solid        = prev_off | (bus.tile_data == SOLID);
    blk_next           = blk;
    blk_next[prev_dir] = blk[prev_dir] | probe_solid;
  end

  // Scan sequencer: flags and done are loaded on the DRAIN edge so they
  // appear together in the COMMIT cycle, and never show partial results
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      k        <= 3'd0;
      prev_dir <= 2'd0;
      prev_off <= 1'b0;
      x_lat    <= 10'd0;
      y_lat    <= 10'd0;
      blk      <= 4'd0;
      flags    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            x_lat  <= bus.pos_x;
            y_lat  <= bus.pos_y;
            blk    <= 4'd0;
            k      <= 3'd0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (k != 3'd0) begin
            blk <= blk_next;
          end
          prev_dir <= k[2:1];
          prev_off <= gen_off;
          k        <= k + 3'd1;
          if (k == 3'd7) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          blk    <= blk_next;
          flags  <= ~blk_next;
          done_q <= 1'b1;
          state  <= COMMIT;
        end
        COMMIT: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tile_addr = (state == SCAN) ? gen_addr : 11'd0;
  assign bus.fLeft     = flags[0];
  assign bus.fRight    = flags[1];
  assign bus.fTop      = flags[2];
  assign bus.fBottom   = flags[3];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = busy_q & bus.frame_start & Reset_n;

endmodule

// File: tb/tb_collision_probe.sv
// Directed bench for collision_probe: a behavioural tile ROM, an independent
// integer model of the probe geometry, and queues of expected addresses and
// flags that are consumed as the DUT drives addresses and pulses done.
module tb_collision_probe;
  import fbwg_pkg::*;

  localparam int HALF_TB    = 13;
  localparam int STEP_X_TB  = 3;
  localparam int STEP_UP_TB = 5;
  localparam int STEP_DN_TB = 2;

  logic Clk = 1'b0;
  logic Reset_n;

  collision_probe_if bus();

  collision_probe #(
    .HALF    (HALF_TB),
    .STEP_X  (STEP_X_TB),
    .STEP_UP (STEP_UP_TB),
    .STEP_DN (STEP_DN_TB),
    .SOLID   (2'b01)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // 100 MHz style free-running clock
  always #5 Clk = ~Clk;

  // Tile-map ROM with one cycle of read latency
  logic [1:0] rom [0:2047];
  always @(posedge Clk) bus.tile_data <= rom[bus.tile_addr];

  int compared   = 0;
  int mismatched = 0;

  logic [10:0] addr_q [$];
  logic [3:0]  flag_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic reportMissing(input string tag);
    compared++;
    mismatched++;
    $error("[TB] FAIL %s: observed no expectation queued expected one", tag);
  endtask

  task automatic clearMap();
    for (int i = 0; i < 2048; i++) rom[i] = EMPTY;
  endtask

  task automatic setTile(input int row, input int col, input tile_t code);
    rom[row * MAP_COLS + col] = code;
  endtask

  // Probe geometry written directly from the character box
  function automatic void probePoint(input int k, input int x, input int y,
                                     output int px, output int py);
    int left_x, right_x, in_left, in_right, in_top, in_bot;
    left_x   = x - HALF_TB - STEP_X_TB;
    right_x  = x + HALF_TB + STEP_X_TB;
    in_left  = x - HALF_TB + 1;
    in_right = x + HALF_TB - 1;
    in_top   = y - HALF_TB + 1;
    in_bot   = y + HALF_TB - 1;
    case (k)
      0: begin px = left_x;   py = in_top; end
      1: begin px = left_x;   py = in_bot; end
      2: begin px = right_x;  py = in_top; end
      3: begin px = right_x;  py = in_bot; end
      4: begin px = in_left;  py = y - HALF_TB - STEP_UP_TB; end
      5: begin px = in_right; py = y - HALF_TB - STEP_UP_TB; end
      6: begin px = in_left;  py = y + HALF_TB + STEP_DN_TB; end
      default: begin px = in_right; py = y + HALF_TB + STEP_DN_TB; end
    endcase
  endfunction

  // Runs one scan: queues expectations, pulses frame_start, then checks
  // every cycle up to T+12. fs2_cyc injects a second frame_start in that
  // cycle; rst_cyc pulls reset in that cycle and checks the abort.
  task automatic applyStimulus(input string tag, input int x, input int y,
                               input int fs2_cyc, input int rst_cyc);
    int px, py, addr;
    bit off, aborted;
    logic [3:0] ef;
    logic [3:0] got;
    ef = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      probePoint(k, x, y, px, py);
      off  = (px < 0) || (px > 639) || (py < 0) || (py > 479);
      addr = off ? 0 : (py / 16) * MAP_COLS + (px / 16);
      addr_q.push_back(11'(addr));
      if (off || rom[addr] == WALL) ef[k / 2] = 1'b0;
    end
    flag_q.push_back(ef);

    @(negedge Clk);
    bus.pos_x       = 10'(x);
    bus.pos_y       = 10'(y);
    bus.frame_start = 1'b1;
    #1 checkOutput({tag, " overrun_at_T"}, 32'(bus.overrun), 32'd0);
    aborted = 1'b0;

    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge Clk);
      got = {bus.fBottom, bus.fTop, bus.fRight, bus.fLeft};
      if (aborted) begin
        checkOutput($sformatf("%s rst_busy", tag), 32'(bus.busy), 32'd0);
        checkOutput($sformatf("%s rst_flags", tag), 32'(got), 32'd0);
        checkOutput($sformatf("%s rst_addr", tag), 32'(bus.tile_addr), 32'd0);
        checkOutput($sformatf("%s rst_done", tag), 32'(bus.done), 32'd0);
        Reset_n = 1'b1;
        addr_q.delete();
        flag_q.delete();
        break;
      end
      checkOutput($sformatf("%s busy c%0d", tag, cyc), 32'(bus.busy), 32'(cyc <= 10));
      checkOutput($sformatf("%s done c%0d", tag, cyc), 32'(bus.done), 32'(cyc == 10));
      if (cyc <= 8) begin
        if (addr_q.size() == 0) reportMissing($sformatf("%s addr c%0d", tag, cyc));
        else checkOutput($sformatf("%s addr k%0d", tag, cyc - 1),
                         32'(bus.tile_addr), 32'(addr_q.pop_front()));
      end
      if (bus.done) begin
        if (flag_q.size() == 0) reportMissing($sformatf("%s flags c%0d", tag, cyc));
        else checkOutput($sformatf("%s flags", tag), 32'(got), 32'(flag_q.pop_front()));
      end
      bus.frame_start = (cyc == fs2_cyc);
      if (cyc == 1 || cyc == fs2_cyc) begin
        bus.pos_x = 10'd14;
        bus.pos_y = 10'd470;
      end
      if (cyc == rst_cyc) begin
        Reset_n = 1'b0;
        aborted = 1'b1;
      end
      #1 checkOutput($sformatf("%s overrun c%0d", tag, cyc), 32'(bus.overrun),
                     32'(cyc == fs2_cyc));
    end
    bus.frame_start = 1'b0;
    checkOutput({tag, " pending"}, 32'(flag_q.size()), 32'd0);
  endtask

  // Directed sequence: reset, open field, floor, screen edges, wall,
  // overrun and mid-scan reset
  initial begin
    Reset_n         = 1'b0;
    bus.frame_start = 1'b0;
    bus.pos_x       = 10'd0;
    bus.pos_y       = 10'd0;
    clearMap();
    repeat (3) @(negedge Clk);
    checkOutput("reset flags", 32'({bus.fBottom, bus.fTop, bus.fRight, bus.fLeft}), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset overrun", 32'(bus.overrun), 32'd0);
    checkOutput("reset addr", 32'(bus.tile_addr), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    $display("[TB] open field");
    applyStimulus("open", 320, 240, -1, -1);

    $display("[TB] floor at row 16");
    for (int c = 0; c < MAP_COLS; c++) setTile(16, c, WALL);
    applyStimulus("floor240", 320, 240, -1, -1);
    applyStimulus("floor241", 320, 241, -1, -1);

    $display("[TB] screen edges");
    clearMap();
    applyStimulus("left_edge", 14, 240, -1, -1);
    applyStimulus("right_edge", 626, 240, -1, -1);
    applyStimulus("top_edge", 320, 17, -1, -1);
    applyStimulus("bottom_edge", 320, 470, -1, -1);

    $display("[TB] wall at col 21");
    setTile(14, 21, WALL);
    setTile(15, 21, WALL);
    setTile(13, 19, WATER);
    setTile(15, 20, LAVA);
    applyStimulus("wall", 320, 240, -1, -1);

    $display("[TB] overrun and mid-scan reset");
    clearMap();
    applyStimulus("overrun", 320, 240, 5, -1);
    applyStimulus("midreset", 14, 240, -1, 6);
    applyStimulus("after_reset", 14, 240, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/collision_probe.md
# collision_probe

Per-frame terrain sensor for the player characters. On each frame-start pulse, it samples the level tile map at eight probe points around the character's current centre. It then publishes four "direction free" flags, `fLeft`, `fRight`, `fTop` and `fBottom`, which the character motion stage consumes on its next frame tick. The block sits between the tile-map ROM and the character motion stage; one instance per character.

## Interface
Parameters:
- `HALF`, 13: character half-extent in pixels (matches character size output)
- `STEP_X`, 3: horizontal probe distance beyond edge (walk speed)
- `STEP_UP`, 5: upward probe distance (jump speed)
- `STEP_DN`, 2: downward probe distance (fall speed)
- `SOLID`, 2'b01: tile code treated as solid

Ports:
- `Clk`  in  1  system clock
- `Reset_n`  in  1  synchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse, start of vertical blank
- `pos_x`  in  10  character centre X (pixels, 0..639)
- `pos_y`  in  10  character centre Y (pixels, 0..479)
- `tile_addr`  out  11  tile-map ROM address, row*40+col
- `tile_data`  in  2  ROM data, valid one cycle after `tile_addr`
- `fLeft`, `fRight`, `fTop`, `fBottom`  out  1 each  1 = direction free, 0 = blocked
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse, flags updated
- `overrun`  out  1  one-cycle pulse, `frame_start` arrived while busy

## Operation
- FSM states: IDLE, SCAN, DRAIN, COMMIT.
- **IDLE:**
  - `frame_start`=1 → latch `pos_x`/`pos_y`, clear the accumulator, go to SCAN with index k=0.
- **SCAN:**
  - Drive `tile_addr` for probe k; k increments each cycle.
  - Probe results are accumulated from `tile_data` one cycle later.
  - After k=7, go to DRAIN.
- **DRAIN:** accumulate probe 7, then go to COMMIT.
- **COMMIT:** write all four flags simultaneously, pulse `done`, return to IDLE.
- Probe points (x,y), with X=latched x and Y=latched y:
  - k0/k1, left: (X−HALF−STEP_X, Y−HALF+1) and (X−HALF−STEP_X, Y+HALF−1)
  - k2/k3, right: X+HALF+STEP_X, same Y pair as left
  - k4/k5, top: (X−HALF+1, Y−HALF−STEP_UP) and (X+HALF−1, Y−HALF−STEP_UP)
  - k6/k7, bottom: Y+HALF+STEP_DN, same X pair as top
- Coordinate arithmetic is 11-bit signed.
  - A probe with x<0, x>639, y<0 or y>479 is off-screen and forced solid.
  - For an off-screen probe, `tile_addr` is driven to 0 and `tile_data` is ignored.
- Address = (y>>4)*40 + (x>>4), computed as (row<<5)+(row<<3)+col; no multiplier.
- A probe is solid iff `tile_data`==SOLID. Other codes (hazards, empty) are passable.
- Each flag = 1 only if both of its probes are non-solid.
- `frame_start` while busy:
  - the pulse is ignored and the scan continues;
  - `overrun` pulses in the same cycle.
- Flags hold their previous values throughout a scan; no partial updates are visible.

## Timing
- Reset (`Reset_n`=0 at a rising edge) forces:
  - all four flags=0 (blocked, so the character is stationary and does not fall);
  - `busy`=0, `done`=0, `overrun`=0, `tile_addr`=0;
  - FSM to IDLE.
- Reset mid-scan aborts the scan; flags go to 0, not to partial results.
- Cycle T: `frame_start` sampled high in IDLE.
- T+1..T+8: addresses k0..k7 driven; `busy`=1.
- T+2..T+9: data returns.
- T+10: COMMIT. New flags and `done`=1 are visible in T+10; `busy` drops in T+11.
- A `frame_start` in T+11 or later starts a new scan. Minimum scan period: 11 cycles.
- `pos_x`/`pos_y` are sampled only at T; later changes do not affect the scan in progress.

## Structure
- Shared package `fbwg_pkg`:
  - screen width/height (640/480);
  - `TILE_SHIFT`=4 and `MAP_COLS`=40;
  - tile-code enum (`EMPTY`, `WALL`, `WATER`, `LAVA`);
  - FSM state enum type.
- One sub-module, `probe_point_gen`, is natural:
  - combinational;
  - inputs: k, latched position and the parameters;
  - outputs: `tile_addr` and an off-screen bit.
- The top level holds the FSM, the counter, the one-cycle-delayed off-screen bit and the per-direction accumulators.

## Test plan
- Open field (all tiles EMPTY), pos (320,240), one `frame_start` → `done` at T+10; all flags=1; `tile_addr` sequence matches the computed rows/cols.
- Floor: row 16 (y 256..271) all WALL, pos (320,240) → bottom probe y=255 is row 15, so `fBottom`=1. Pos (320,241) → probe y=256, so `fBottom`=0; other flags=1.
- Left screen edge: pos (14,240) → left probe x=−2 is off-screen, so `fLeft`=0 with no ROM dependence; `fRight`=1.
- Wall at col 21 (x 336..351) WALL only for rows 14..15, pos (320,240) → right probe x=336 hits WALL at y=228 (row 14); `fRight`=0.
- Second `frame_start` at T+5 → `overrun` pulses at T+5, exactly one `done` (T+10), results from the first position.
- `Reset_n` low at T+6 mid-scan → flags=0 and `busy`=0 next cycle; a fresh `frame_start` then completes normally.
